// File: rtl/product_bcd_converter.sv
// product_bcd_converter: sequential double-dabble conversion of an N-bit
// unsigned value into DIGITS packed BCD digits, one bit per clock.
// Optional feature macro: LEADING_ZERO_BLANK_EN adds a per-digit
// leading-zero blank mask. When the macro is undefined, Blank is tied to zero.
module product_bcd_converter #(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [N-1:0]          Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     Blank
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         count;
    logic [N-1:0]          shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   scratch_adj;

    // Add 3 to every digit that is 5 or more so the following shift carries
    // correctly into the next decimal digit.
    function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] s);
        logic [4*DIGITS-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Bit i (i >= 1) is set when digit i and every digit above it are zero;
    // the units digit is never blanked so a zero value still shows "0".
    function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] m;
        logic              upper_zero;
        m          = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (d[4*i +: 4] == 4'd0);
            m[i]       = upper_zero;
        end
        return m;
    endfunction
`endif

    assign scratch_adj = dabble_adjust(scratch);
    assign Busy        = (state != IDLE);

    // State register; reset aborts any conversion in progress.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: N shift cycles, then one FINISH cycle that publishes.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit counter: loaded on capture, counts down once per shift.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (state == IDLE && Start) begin
            count <= CW'(N);
        end else if (state == SHIFT) begin
            count <= count - CW'(1);
        end
    end

    // Working datapath: capture the operand, then adjust-and-shift each cycle.
    always_ff @(posedge Clk) begin
        if (state == IDLE && Start) begin
            shreg   <= Bin;
            scratch <= '0;
        end else if (state == SHIFT) begin
            scratch <= {scratch_adj[4*DIGITS-2:0], shreg[N-1]};
            shreg   <= {shreg[N-2:0], 1'b0};
        end
    end

    // Published result and completion pulse; only FINISH updates them.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Done <= 1'b0;
            BCD  <= '0;
        end else begin
            Done <= (state == FINISH);
            if (state == FINISH) begin
                BCD <= scratch;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank mask follows the published result; reset value matches BCD = 0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Blank <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else if (state == FINISH) begin
            Blank <= blank_mask(scratch);
        end
    end
`else
    assign Blank = '0;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: stimulus pushes expected
// results, a negedge monitor pops and compares on every Done pulse.
module tb_product_bcd_converter;

    localparam int N      = 16;
    localparam int DIGITS = 5;

    logic                clk;
    logic                reset;
    logic                start;
    logic [N-1:0]        bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    product_bcd_converter #(.N(N), .DIGITS(DIGITS)) dut (
        .Clk   (clk),
        .Reset (reset),
        .Start (start),
        .Bin   (bin),
        .Busy  (busy),
        .Done  (done),
        .BCD   (bcd),
        .Blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DIGITS-1:0] exp_blank(input logic [DIGITS-1:0] on_val);
`ifdef LEADING_ZERO_BLANK_EN
        return on_val;
`else
        if (on_val != '1) return '0;
        return '0;
`endif
    endfunction

    // Monitor: every Done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=bcd_%h required=no_done (cycle %0d)", bcd, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bcd_value", {12'd0, bcd}, {12'd0, e.bcd});
                check("blank_mask", {27'd0, blank}, {27'd0, e.blank});
                check("done_latency", cyc, e.cyc);
            end
        end
        prev_done = done;
    end

    // Issue one conversion; Start is sampled at the next rising edge k and
    // Done is expected to be visible at the negedge following edge k+N+1.
    task automatic convert(input logic [N-1:0] b, input logic [4*DIGITS-1:0] eb,
                           input logic [DIGITS-1:0] ebl);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        e.bcd   = eb;
        e.blank = exp_blank(ebl);
        e.cyc   = cyc + N + 2;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int c0;
        exp_t e;
        start = 1'b0;
        bin   = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_bcd", {12'd0, bcd}, 32'd0);
        check("reset_blank", {27'd0, blank}, {27'd0, exp_blank(5'b11110)});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Zero input.
        convert(16'h0000, 20'h00000, 5'b11110);
        drain("drain_zero");

        // Full-scale input, with Busy duration measured.
        @(negedge clk);
        start = 1'b1;
        bin   = 16'hFFFF;
        e.bcd = 20'h65535; e.blank = exp_blank(5'b00000); e.cyc = cyc + N + 2;
        q.push_back(e);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 17);
        drain("drain_ffff");

        // Second Start during a conversion is ignored; Bin changes don't matter.
        @(negedge clk);
        c0    = cyc;
        start = 1'b1;
        bin   = 16'h3039;
        e.bcd = 20'h12345; e.blank = exp_blank(5'b00000); e.cyc = c0 + N + 2;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bin   = 16'hAAAA;
        while (cyc < c0 + 5) @(negedge clk);
        start = 1'b1;
        bin   = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        drain("drain_ignore");
        repeat (30) @(negedge clk);

        // Reset asserted mid-conversion aborts without a Done.
        @(negedge clk);
        c0    = cyc;
        start = 1'b1;
        bin   = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 9) @(posedge clk);
        #1;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {12'd0, bcd}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);

        // First conversion after reset, small value with leading zeros.
        convert(16'd7, 20'h00007, 5'b11110);
        drain("drain_seven");

        // Start held high: three back-to-back conversions, 18 cycles apart.
        @(negedge clk);
        c0    = cyc;
        start = 1'b1;
        bin   = 16'd9999;
        for (int i = 0; i < 3; i++) begin
            e.bcd = 20'h09999; e.blank = exp_blank(5'b10000); e.cyc = c0 + N + 2 + i * (N + 2);
            q.push_back(e);
        end
        while (cyc < c0 + 2 * (N + 2) + 1) @(negedge clk);
        start = 1'b0;
        drain("drain_b2b");
        repeat (30) @(negedge clk);
        check("no_stray_results", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_bcd_converter.md
PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 SHALL have parameter N, default 16: binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 5: number of BCD output digits; 10^DIGITS SHALL exceed 2^N-1.
REQ-003 SHALL have port Clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port Reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1: request to convert Bin, sampled at Clk rising edge.
REQ-006 SHALL have port Bin  input  N: unsigned binary value, e.g. the registered product P.
REQ-007 SHALL have port Busy  output  1: high while a conversion is in progress.
REQ-008 SHALL have port Done  output  1: one-cycle pulse marking BCD update.
REQ-009 SHALL have port BCD  output  4*DIGITS: packed result, digit 0 (units) in bits [3:0].
REQ-010 SHALL have port Blank  output  DIGITS: per-digit leading-zero blank mask, bit i for digit i.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT, FINISH.
REQ-012 IDLE with Start=1: SHALL capture Bin into a shift register, clear the BCD scratch, load the bit counter with N, and go to SHIFT.
REQ-013 IDLE with Start=0: SHALL hold all outputs.
REQ-014 SHIFT, each cycle: SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by 1 and decrement the counter (double-dabble).
REQ-015 SHALL leave SHIFT for FINISH after exactly N shift cycles.
REQ-016 FINISH: SHALL copy the scratch to BCD and update Blank, assert Done for that one cycle, and return to IDLE.
REQ-017 Latency: Start sampled at edge k SHALL give BCD valid and Done=1 after edge k+N+1 (edge k+17 for N=16).
REQ-018 Busy SHALL be 1 in SHIFT and FINISH and 0 in IDLE.
REQ-019 Start while Busy=1 SHALL be ignored, with no queuing; Bin changes after capture SHALL NOT affect the result.
REQ-020 BCD and Blank SHALL hold the last completed result until the next FINISH; no intermediate values SHALL be visible.
REQ-021 Start held high continuously SHALL start a new conversion in the cycle after FINISH, giving back-to-back conversions every N+2 cycles.
REQ-022 Every BCD digit SHALL be in 0..9 for all Bin in 0..2^N-1.

Reset
REQ-023 Reset=0 SHALL immediately force IDLE, counter=0, BCD=0, Busy=0, and Done=0, independent of Clk.
REQ-024 Reset=0 SHALL force Blank to all-ones except bit 0 when LEADING_ZERO_BLANK_EN is defined, and to all zeros otherwise.
REQ-025 Reset asserted mid-conversion SHALL abort it, with no Done and no partial BCD.
REQ-026 After Reset is released, the first Start SHALL behave per REQ-012.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: Blank bit i SHALL be 1 iff digit i and all higher digits are 0, for i >= 1.
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: Blank bit 0 SHALL always be 0, so value 0 displays "0".
REQ-029 Macro LEADING_ZERO_BLANK_EN undefined: Blank SHALL be tied to all zeros, and no blank-detection logic SHALL be synthesized.

Verification
REQ-030 A bench SHALL check: reset, then Start with Bin=16'h0000 -> Done at edge k+17, BCD=20'h00000.
REQ-031 A bench SHALL check: Start with Bin=16'hFFFF -> BCD=20'h65535, Busy high for 17 cycles, Done high for exactly 1 cycle.
REQ-032 A bench SHALL check: Start with Bin=16'h3039, then Start pulse and Bin=16'h0001 at edge k+5 -> BCD=20'h12345, and the second Start is ignored.
REQ-033 A bench SHALL check: Start with Bin=16'h1234, then Reset=0 at edge k+8 -> Busy=0, BCD=0, and no Done pulse.
REQ-034 A bench SHALL check, with LEADING_ZERO_BLANK_EN defined: Bin=16'd7 -> BCD=20'h00007 and Blank=5'b11110; Bin=0 -> Blank=5'b11110.
REQ-035 A bench SHALL check: Start held high for 3 conversions of Bin=16'd9999 -> Done pulses 18 cycles apart, and BCD=20'h09999 each time.
